// File: rtl/mac_head_tx_stream.sv
`default_nettype none
// ============================================================================
// Module      : mac_head_tx_stream
// Description : Prepends preamble/SFD, MAC addresses, optional 802.1Q tag
//               (macro MAC_VLAN_EN) and EtherType to each payload frame,
//               realigning payload bytes behind the header.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_head_tx_stream #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = $clog2(DATA_W/8)+1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [47:0]       dst_addr_i,
  input  logic [47:0]       src_addr_i,
  input  logic [15:0]       ethertype_i,
`ifdef MAC_VLAN_EN
  input  logic [2:0]        pcp_i,
  input  logic              dei_i,
  input  logic [11:0]       vid_i,
`endif
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  input  logic [KEEP_W-1:0] in_keep_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic [KEEP_W-1:0] out_keep_o,
  output logic [15:0]       frame_cnt_o
);

  localparam int c_bytes = DATA_W/8;
`ifdef MAC_VLAN_EN
  localparam int c_hdr_len = 26;
`else
  localparam int c_hdr_len = 22;
`endif
  localparam int c_hdr_w      = c_hdr_len*8;
  localparam int c_head_beats = c_hdr_len / c_bytes;
  localparam int c_rem        = c_hdr_len % c_bytes;
  localparam logic [DATA_W-1:0] c_carry_mask = ~({DATA_W{1'b1}} << (c_rem*8));
  localparam logic [KEEP_W:0]   c_bytes_k    = (KEEP_W+1)'(c_bytes);
  localparam logic [KEEP_W:0]   c_rem_k      = (KEEP_W+1)'(c_rem);
  localparam logic [KEEP_W-1:0] c_full_keep  = KEEP_W'(c_bytes);
  localparam logic [7:0]        c_last_head  = 8'(c_head_beats-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HEAD  = 2'd1,
    S_BODY  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_hdr_w-1:0]  r_hdr;
  logic [7:0]          r_cnt;
  logic [KEEP_W-1:0]   r_flush_keep;

  logic [c_hdr_w-1:0]  w_hdr;
  logic                w_out_free;
  logic                w_in_fire;
  logic [KEEP_W:0]     w_in_n;
  logic [KEEP_W:0]     w_sum;
  logic [DATA_W-1:0]   w_body_data;
  logic [DATA_W-1:0]   w_carry_next;

  always_comb begin
    w_hdr = '0;
    for (int i = 0; i < 7; i++) w_hdr[8*i +: 8] = 8'h55;
    w_hdr[8*7 +: 8] = 8'hD5;
    for (int i = 0; i < 6; i++) begin
      w_hdr[8*(8+i)  +: 8] = dst_addr_i[8*(5-i) +: 8];
      w_hdr[8*(14+i) +: 8] = src_addr_i[8*(5-i) +: 8];
    end
`ifdef MAC_VLAN_EN
    w_hdr[8*20 +: 8] = 8'h81;
    w_hdr[8*21 +: 8] = 8'h00;
    w_hdr[8*22 +: 8] = {pcp_i, dei_i, vid_i[11:8]};
    w_hdr[8*23 +: 8] = vid_i[7:0];
`endif
    w_hdr[8*(c_hdr_len-2) +: 8] = ethertype_i[15:8];
    w_hdr[8*(c_hdr_len-1) +: 8] = ethertype_i[7:0];
  end

  assign w_out_free   = !out_valid_o || out_ready_i;
  assign in_ready_o   = (r_state == S_BODY) && w_out_free;
  assign w_in_fire    = in_valid_i && in_ready_o;
  assign w_in_n       = (in_keep_i == '0) ? c_bytes_k : {1'b0, in_keep_i};
  assign w_sum        = w_in_n + c_rem_k;
  // Low lanes of r_hdr hold the leftover header bytes, then the payload carry
  assign w_body_data  = (in_data_i << (c_rem*8)) | (r_hdr[DATA_W-1:0] & c_carry_mask);
  assign w_carry_next = in_data_i >> ((c_bytes-c_rem)*8);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= S_IDLE;
      r_hdr        <= '0;
      r_cnt        <= '0;
      r_flush_keep <= '0;
      out_valid_o  <= 1'b0;
      out_data_o   <= '0;
      out_last_o   <= 1'b0;
      out_keep_o   <= '0;
      frame_cnt_o  <= '0;
    end else begin
      if (out_valid_o && out_ready_i) begin
        out_valid_o <= 1'b0;
        if (out_last_o) frame_cnt_o <= frame_cnt_o + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          // Waiting for !out_valid_o guarantees one idle cycle between frames
          if (in_valid_i && !out_valid_o) begin
            out_valid_o <= 1'b1;
            out_data_o  <= w_hdr[DATA_W-1:0];
            out_last_o  <= 1'b0;
            out_keep_o  <= c_full_keep;
            r_hdr       <= w_hdr >> DATA_W;
            r_cnt       <= 8'd1;
            r_state     <= S_HEAD;
          end
        end
        S_HEAD: begin
          if (w_out_free) begin
            out_valid_o <= 1'b1;
            out_data_o  <= r_hdr[DATA_W-1:0];
            out_last_o  <= 1'b0;
            out_keep_o  <= c_full_keep;
            r_hdr       <= r_hdr >> DATA_W;
            r_cnt       <= r_cnt + 8'd1;
            if (r_cnt == c_last_head) r_state <= S_BODY;
          end
        end
        S_BODY: begin
          if (w_in_fire) begin
            out_valid_o <= 1'b1;
            out_data_o  <= w_body_data;
            r_hdr       <= c_hdr_w'(w_carry_next);
            if (in_last_i && (w_sum > c_bytes_k)) begin
              out_last_o   <= 1'b0;
              out_keep_o   <= c_full_keep;
              r_flush_keep <= KEEP_W'(w_sum - c_bytes_k);
              r_state      <= S_FLUSH;
            end else if (in_last_i) begin
              out_last_o <= 1'b1;
              out_keep_o <= KEEP_W'(w_sum);
              r_state    <= S_IDLE;
            end else begin
              out_last_o <= 1'b0;
              out_keep_o <= c_full_keep;
            end
          end
        end
        S_FLUSH: begin
          if (w_out_free) begin
            out_valid_o <= 1'b1;
            out_data_o  <= r_hdr[DATA_W-1:0] & c_carry_mask;
            out_last_o  <= 1'b1;
            out_keep_o  <= r_flush_keep;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_head_tx_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_head_tx_stream
// Description : Scoreboard bench for mac_head_tx_stream (DATA_W = 64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_head_tx_stream;

  localparam int DATA_W = 64;
  localparam int BYTES  = 8;
  localparam int KEEP_W = 4;
`ifdef MAC_VLAN_EN
  localparam int HLEN = 26;
`else
  localparam int HLEN = 22;
`endif

  logic              clk = 1'b0;
  logic              nreset;
  logic [47:0]       dst_addr_i, src_addr_i;
  logic [15:0]       ethertype_i;
`ifdef MAC_VLAN_EN
  logic [2:0]        pcp_i;
  logic              dei_i;
  logic [11:0]       vid_i;
`endif
  logic              in_valid_i, in_ready_o, in_last_i;
  logic [DATA_W-1:0] in_data_i;
  logic [KEEP_W-1:0] in_keep_i;
  logic              out_valid_o, out_last_o;
  logic              out_ready_i = 1'b1;
  logic [DATA_W-1:0] out_data_o;
  logic [KEEP_W-1:0] out_keep_o;
  logic [15:0]       frame_cnt_o;

  mac_head_tx_stream #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) dut (
    .clk(clk), .nreset(nreset),
    .dst_addr_i(dst_addr_i), .src_addr_i(src_addr_i), .ethertype_i(ethertype_i),
`ifdef MAC_VLAN_EN
    .pcp_i(pcp_i), .dei_i(dei_i), .vid_i(vid_i),
`endif
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_last_i(in_last_i), .in_keep_i(in_keep_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .out_keep_o(out_keep_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  byte unsigned exp_q[$];
  int len_q[$];
  int beats_q[$];
  int cur_rem = 0, beat_cnt = 0, exp_fc = 0, mode = 0;
  bit mon_en = 1'b0;
  logic [63:0] first_beat = '0;
  int last_beats = 0;
  logic [KEEP_W-1:0] last_keep = '0;
  logic last_in_ready = 1'b0;
  bit hold_pend = 1'b0;
  logic [DATA_W-1:0] hold_data;
  logic hold_last;
  logic [KEEP_W-1:0] hold_keep;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic accept_beat();
    logic [63:0] exp_d, mask;
    int n;
    bit exp_last;
    if (cur_rem == 0) begin
      if (len_q.size() == 0) begin
        chk("unexpected_beat", 64'(len_q.size()), 64'd1);
        return;
      end
      cur_rem    = len_q.pop_front();
      beat_cnt   = 0;
      first_beat = out_data_o;
    end
    exp_last = (cur_rem <= BYTES);
    n = exp_last ? cur_rem : BYTES;
    exp_d = '0;
    mask  = '0;
    for (int i = 0; i < n; i++) begin
      exp_d[8*i +: 8] = exp_q.pop_front();
      mask[8*i +: 8]  = 8'hFF;
    end
    chk("beat_data", out_data_o & mask, exp_d);
    chk("beat_last", 64'(out_last_o), 64'(exp_last));
    chk("beat_keep", 64'(out_keep_o), 64'(n));
    chk("frame_cnt", 64'(frame_cnt_o), 64'(exp_fc));
    cur_rem -= n;
    beat_cnt++;
    if (exp_last) begin
      chk("frame_beats", 64'(beat_cnt), 64'(beats_q.pop_front()));
      last_beats    = beat_cnt;
      last_keep     = out_keep_o;
      last_in_ready = in_ready_o;
      exp_fc        = (exp_fc + 1) & 16'hFFFF;
    end
  endtask

  // Output monitor: drives backpressure, checks holds and scoreboards accepted beats
  always @(negedge clk) begin
    case (mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = ~out_ready_i;
      default: out_ready_i = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (nreset && mon_en) begin
      if (hold_pend) begin
        chk("hold_valid", 64'(out_valid_o), 64'd1);
        chk("hold_data", out_data_o, hold_data);
        chk("hold_last", 64'(out_last_o), 64'(hold_last));
        chk("hold_keep", 64'(out_keep_o), 64'(hold_keep));
      end
      if (out_valid_o && out_ready_i) accept_beat();
      hold_pend = out_valid_o && !out_ready_i;
      hold_data = out_data_o;
      hold_last = out_last_o;
      hold_keep = out_keep_o;
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic send_frame(input int plen, input bit scramble, input bit keep0);
    byte unsigned pl[$];
    int nb, wc, kk, idx;
    logic [63:0] d;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) exp_q.push_back(dst_addr_i[8*i +: 8]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(src_addr_i[8*i +: 8]);
`ifdef MAC_VLAN_EN
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h00);
    exp_q.push_back({pcp_i, dei_i, vid_i[11:8]});
    exp_q.push_back(vid_i[7:0]);
`endif
    exp_q.push_back(ethertype_i[15:8]);
    exp_q.push_back(ethertype_i[7:0]);
    for (int k = 0; k < plen; k++) begin
      pl.push_back(8'($urandom));
      exp_q.push_back(pl[k]);
    end
    len_q.push_back(HLEN + plen);
    beats_q.push_back((HLEN + plen + BYTES - 1) / BYTES);
    nb = (plen + BYTES - 1) / BYTES;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      for (int l = 0; l < BYTES; l++) begin
        idx = b*BYTES + l;
        d[8*l +: 8] = (idx < plen) ? pl[idx] : 8'($urandom);
      end
      in_valid_i = 1'b1;
      in_data_i  = d;
      in_last_i  = (b == nb-1);
      kk = in_last_i ? (plen - b*BYTES) : BYTES;
      if (in_last_i && keep0 && kk == BYTES) kk = 0;
      in_keep_i = KEEP_W'(kk);
      #1;
      wc = 0;
      while (!in_ready_o && wc < 1000) begin
        @(negedge clk);
        #1;
        wc++;
      end
      if (wc >= 1000) begin
        chk("accept_timeout", 64'(wc), 64'd0);
        break;
      end
      if (scramble && b == 0) begin
        dst_addr_i  = {16'($urandom), $urandom()};
        src_addr_i  = {16'($urandom), $urandom()};
        ethertype_i = 16'($urandom);
      end
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic drain();
    int wc = 0;
    while ((len_q.size() != 0 || cur_rem != 0) && wc < 2000) begin
      @(negedge clk);
      #2;
      wc++;
    end
    chk("drain_timeout", 64'(len_q.size() + cur_rem), 64'd0);
    @(negedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wc;
    nreset      = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_last_i   = 1'b0;
    in_keep_i   = '0;
    dst_addr_i  = 48'h0011_2233_4455;
    src_addr_i  = 48'h6677_8899_AABB;
    ethertype_i = 16'h0800;
`ifdef MAC_VLAN_EN
    pcp_i = 3'd3;
    dei_i = 1'b0;
    vid_i = 12'h001;
`endif
    repeat (3) @(negedge clk);
    #2;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_out_data", out_data_o, 64'd0);
    chk("rst_out_last", 64'(out_last_o), 64'd0);
    chk("rst_out_keep", 64'(out_keep_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt_o), 64'd0);
    nreset = 1'b1;
    mon_en = 1'b1;

    // 46-byte payload, EtherType 0x0800
    send_frame(46, 1'b0, 1'b0);
    drain();
    chk("t1_first_beat", first_beat, 64'hD555_5555_5555_5555);
    chk("t1_beats", 64'(last_beats), 64'd9);
`ifdef MAC_VLAN_EN
    chk("t1_keep", 64'(last_keep), 64'd8);
`else
    chk("t1_keep", 64'(last_keep), 64'd4);
`endif
    chk("t1_frame_cnt", 64'(frame_cnt_o), 64'd1);

    // single-beat payload forcing a flush beat
    send_frame(8, 1'b0, 1'b0);
    drain();
`ifdef MAC_VLAN_EN
    chk("t2_beats", 64'(last_beats), 64'd5);
    chk("t2_keep", 64'(last_keep), 64'd2);
`else
    chk("t2_beats", 64'(last_beats), 64'd4);
    chk("t2_keep", 64'(last_keep), 64'd6);
`endif
    chk("t2_flush_ready", 64'(last_in_ready), 64'd0);

    // 64-byte frame with alternating backpressure
    mode = 1;
    send_frame(64, 1'b0, 1'b0);
    drain();
    chk("t3_beats", 64'(last_beats), 64'((HLEN + 64 + BYTES - 1) / BYTES));
    mode = 0;

    // header inputs changed after sampling; keep=0 on a full last beat
    send_frame(30, 1'b1, 1'b0);
    drain();
    send_frame(16, 1'b0, 1'b1);
    drain();

    // random lengths, headers and backpressure
    mode = 2;
    for (int f = 0; f < 8; f++) begin
      dst_addr_i  = {16'($urandom), $urandom()};
      src_addr_i  = {16'($urandom), $urandom()};
      ethertype_i = 16'($urandom);
`ifdef MAC_VLAN_EN
      pcp_i = 3'($urandom);
      dei_i = 1'($urandom);
      vid_i = 12'($urandom);
`endif
      send_frame(int'($urandom_range(1, 70)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    mode = 0;
    chk("pre_reset_frame_cnt", 64'(frame_cnt_o), 64'(exp_fc));

    // reset asserted while payload is streaming
    mon_en = 1'b0;
    @(negedge clk);
    in_valid_i = 1'b1;
    in_last_i  = 1'b0;
    in_keep_i  = KEEP_W'(BYTES);
    in_data_i  = {$urandom(), $urandom()};
    #1;
    wc = 0;
    while (!in_ready_o && wc < 100) begin
      @(negedge clk);
      #1;
      wc++;
    end
    chk("rst_reach_body", 64'(in_ready_o), 64'd1);
    @(negedge clk);
    #2;
    nreset = 1'b0;
    in_valid_i = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 64'(out_valid_o), 64'd0);
    chk("midrst_out_data", out_data_o, 64'd0);
    chk("midrst_out_last", 64'(out_last_o), 64'd0);
    chk("midrst_out_keep", 64'(out_keep_o), 64'd0);
    chk("midrst_in_ready", 64'(in_ready_o), 64'd0);
    chk("midrst_frame_cnt", 64'(frame_cnt_o), 64'd0);
    exp_q.delete();
    len_q.delete();
    beats_q.delete();
    cur_rem = 0;
    exp_fc  = 0;
    @(negedge clk);
    nreset = 1'b1;
    mon_en = 1'b1;
    send_frame(20, 1'b0, 1'b0);
    drain();
    chk("post_rst_first_beat", first_beat, 64'hD555_5555_5555_5555);
    chk("post_rst_frame_cnt", 64'(frame_cnt_o), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
